bitmap_addr_gen: RTL and testbench

// - CPU-side bitmap address generator driving the DRBA/BITMDn/PIXA inputs of the video DRAM.
// - Holds X/Y pixel registers that the CPU writes, and turns a bitmode access into a DRAM nibble address.
// - Auto-steps X/Y after each bitmode access so the CPU can stream pixels along a line or column.
// - Sits between the CPU bus decode and the video DRAM block.

---
 rtl/bitmap_addr_gen.sv | 143 ++++++++++++++
 tb/tb_bitmap_addr_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bitmap_addr_gen.sv
// Bitmap address generator: X/Y pixel registers, bitmode DRAM nibble addressing and X/Y auto-step.
// Optional CPU readback of X/Y is built when BITMAP_READBACK_EN is defined.
module bitmap_addr_gen #(
  parameter logic [15:0] ADDR_X  = 16'h0000,
  parameter logic [15:0] ADDR_Y  = 16'h0001,
  parameter logic [15:0] ADDR_BM = 16'h0002
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_start,
  input  logic        cpu_end,
  input  logic [15:0] AB,
  input  logic        BRWn,
  input  logic [7:0]  BD,
  input  logic        xinc_n,
  input  logic        yinc_n,
  input  logic        xdir,
  input  logic        ydir,
  output logic [14:0] DRBA,
  output logic        BITMDn,
  output logic        PIXA,
  output logic [7:0]  xy_to_cpu,
  output logic        xy_rd_hit
);

  // state | meaning
  // IDLE  | no CPU cycle in progress
  // CYCLE | between cpu_start and cpu_end; address and hit flags held
  typedef enum logic {IDLE, CYCLE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  x, y, x_nxt, y_nxt;
  logic        bm_q, rd_q, hx_q, hy_q;
  logic        ab_bm, ab_hx, ab_hy;
  logic        cur_bm, cur_rd, cur_hx, cur_hy, act;
  logic [14:0] drba_nxt;
  logic        bitmd_n_nxt, pixa_nxt;

  assign ab_bm = (AB == ADDR_BM);
  assign ab_hx = (AB == ADDR_X);
  assign ab_hy = (AB == ADDR_Y);

  // A start and end in the same clk act on the live bus, not the stale latch.
  assign cur_bm = cpu_start ? ab_bm : bm_q;
  assign cur_rd = cpu_start ? BRWn  : rd_q;
  assign cur_hx = cpu_start ? ab_hx : hx_q;
  assign cur_hy = cpu_start ? ab_hy : hy_q;
  assign act    = cpu_end && (cpu_start || state == CYCLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cpu_start)
      state_nxt = cpu_end ? IDLE : CYCLE;
    else if (cpu_end && state == CYCLE)
      state_nxt = IDLE;
  end

  always_comb begin
    x_nxt       = x;
    y_nxt       = y;
    drba_nxt    = DRBA;
    bitmd_n_nxt = BITMDn;
    pixa_nxt    = PIXA;
    if (act) begin
      if (cur_bm) begin
        if (!xinc_n) x_nxt = xdir ? x - 8'd1 : x + 8'd1;
        if (!yinc_n) y_nxt = ydir ? y - 8'd1 : y + 8'd1;
      end else if (!cur_rd) begin
        if (cur_hx) x_nxt = BD;
        if (cur_hy) y_nxt = BD;
      end
    end
    if (cpu_start) begin
      drba_nxt    = ab_bm ? {y, x[7:1]} : AB[14:0];
      bitmd_n_nxt = !ab_bm;
      pixa_nxt    = x[0];
    end else if (cpu_end || state == IDLE) begin
      bitmd_n_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x      <= 8'h00;
      y      <= 8'h00;
      bm_q   <= 1'b0;
      rd_q   <= 1'b1;
      hx_q   <= 1'b0;
      hy_q   <= 1'b0;
      DRBA   <= 15'h0000;
      BITMDn <= 1'b1;
      PIXA   <= 1'b0;
    end else begin
      x      <= x_nxt;
      y      <= y_nxt;
      DRBA   <= drba_nxt;
      BITMDn <= bitmd_n_nxt;
      PIXA   <= pixa_nxt;
      if (cpu_start) begin
        bm_q <= ab_bm;
        rd_q <= BRWn;
        hx_q <= ab_hx;
        hy_q <= ab_hy;
      end
    end
  end

`ifdef BITMAP_READBACK_EN
  logic [7:0] rb_data_nxt;
  logic       rb_hit_nxt;

  always_comb begin
    rb_data_nxt = xy_to_cpu;
    rb_hit_nxt  = xy_rd_hit;
    if (cpu_start) begin
      rb_hit_nxt  = BRWn && (ab_hx || ab_hy);
      rb_data_nxt = !BRWn ? 8'hFF : ab_hx ? x : ab_hy ? y : 8'hFF;
    end else if (cpu_end || state == IDLE) begin
      rb_hit_nxt  = 1'b0;
      rb_data_nxt = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xy_to_cpu <= 8'hFF;
      xy_rd_hit <= 1'b0;
    end else begin
      xy_to_cpu <= rb_data_nxt;
      xy_rd_hit <= rb_hit_nxt;
    end
  end
`else
  assign xy_to_cpu = 8'hFF;
  assign xy_rd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bitmap_addr_gen.sv
// Directed bench for bitmap_addr_gen; X/Y are observed through bitmode DRBA/PIXA.
module tb_bitmap_addr_gen;

  localparam logic [15:0] ADDR_X  = 16'h0000;
  localparam logic [15:0] ADDR_Y  = 16'h0001;
  localparam logic [15:0] ADDR_BM = 16'h0002;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_start = 1'b0, cpu_end = 1'b0;
  logic [15:0] AB = 16'h0000;
  logic        BRWn = 1'b1;
  logic [7:0]  BD = 8'h00;
  logic        xinc_n = 1'b1, yinc_n = 1'b1, xdir = 1'b0, ydir = 1'b0;
  logic [14:0] DRBA;
  logic        BITMDn, PIXA;
  logic [7:0]  xy_to_cpu;
  logic        xy_rd_hit;

  int n_checks = 0;
  int n_errors = 0;

  bitmap_addr_gen #(.ADDR_X(ADDR_X), .ADDR_Y(ADDR_Y), .ADDR_BM(ADDR_BM)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_start(cpu_start), .cpu_end(cpu_end),
    .AB(AB), .BRWn(BRWn), .BD(BD), .xinc_n(xinc_n), .yinc_n(yinc_n),
    .xdir(xdir), .ydir(ydir), .DRBA(DRBA), .BITMDn(BITMDn), .PIXA(PIXA),
    .xy_to_cpu(xy_to_cpu), .xy_rd_hit(xy_rd_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_cycle(input logic [15:0] a, input logic rw);
    @(posedge clk); #1;
    cpu_start = 1'b1; AB = a; BRWn = rw;
    @(posedge clk); #1;
    cpu_start = 1'b0;
  endtask

  task automatic end_cycle(input logic [7:0] d);
    BD = d; cpu_end = 1'b1;
    @(posedge clk); #1;
    cpu_end = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    start_cycle(a, 1'b0);
    end_cycle(d);
  endtask

  // Non-stepping bitmode read to expose {Y, X[7:1]} and X[0].
  task automatic peek(input string tag, input logic [14:0] exp_drba, input logic exp_pixa);
    logic sx, sy;
    sx = xinc_n; sy = yinc_n;
    xinc_n = 1'b1; yinc_n = 1'b1;
    start_cycle(ADDR_BM, 1'b1);
    check({tag, "_bitmd"}, {31'd0, BITMDn}, 32'd0);
    check({tag, "_drba"}, {17'd0, DRBA}, {17'd0, exp_drba});
    check({tag, "_pixa"}, {31'd0, PIXA}, {31'd0, exp_pixa});
    end_cycle(8'h00);
    xinc_n = sx; yinc_n = sy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] exp_d [3];
    logic        exp_p [3];
    exp_d[0] = 15'h407F; exp_d[1] = 15'h407F; exp_d[2] = 15'h4000;
    exp_p[0] = 1'b0;     exp_p[1] = 1'b1;     exp_p[2] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_drba",  {17'd0, DRBA}, 32'd0);
    check("rst_bitmd", {31'd0, BITMDn}, 32'd1);
    check("rst_pixa",  {31'd0, PIXA}, 32'd0);
    check("rst_xy",    {24'd0, xy_to_cpu}, 32'hFF);
    check("rst_hit",   {31'd0, xy_rd_hit}, 32'd0);
    reset_n = 1'b1;

    // X=35, Y=80 -> {80, 1A}, PIXA=1
    cpu_write(ADDR_X, 8'h35);
    cpu_write(ADDR_Y, 8'h80);
    start_cycle(ADDR_BM, 1'b0);
    check("bm_bitmd", {31'd0, BITMDn}, 32'd0);
    check("bm_drba",  {17'd0, DRBA}, 32'h401A);
    check("bm_pixa",  {31'd0, PIXA}, 32'd1);
    end_cycle(8'h00);
    check("bm_end_bitmd", {31'd0, BITMDn}, 32'd1);

    // X increments across the FF->00 wrap; Y stays 80
    cpu_write(ADDR_X, 8'hFE);
    xinc_n = 1'b0; xdir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_cycle(ADDR_BM, 1'b0);
      check($sformatf("wrap%0d_drba", i), {17'd0, DRBA}, {17'd0, exp_d[i]});
      check($sformatf("wrap%0d_pixa", i), {31'd0, PIXA}, {31'd0, exp_p[i]});
      end_cycle(8'h00);
    end
    xinc_n = 1'b1;
    peek("wrap_final", 15'h4000, 1'b1);

    // X=10,Y=00 both decrement -> X=0F, Y=FF
    cpu_write(ADDR_X, 8'h10);
    cpu_write(ADDR_Y, 8'h00);
    xinc_n = 1'b0; yinc_n = 1'b0; xdir = 1'b1; ydir = 1'b1;
    start_cycle(ADDR_BM, 1'b1);
    check("dec_drba", {17'd0, DRBA}, 32'h0008);
    end_cycle(8'h00);
    xinc_n = 1'b1; yinc_n = 1'b1;
    peek("dec_final", 15'h7F87, 1'b1);

    // Same-clk start/end: 1-clk bitmode cycle, X 0F -> 10
    xinc_n = 1'b0; xdir = 1'b0;
    @(posedge clk); #1;
    cpu_start = 1'b1; cpu_end = 1'b1; AB = ADDR_BM; BRWn = 1'b1;
    @(posedge clk); #1;
    cpu_start = 1'b0; cpu_end = 1'b0;
    check("one_bitmd", {31'd0, BITMDn}, 32'd0);
    check("one_drba",  {17'd0, DRBA}, 32'h7F87);
    @(posedge clk); #1;
    check("one_idle_bitmd", {31'd0, BITMDn}, 32'd1);
    xinc_n = 1'b1;
    peek("one_final", 15'h7F88, 1'b0);

    // Non-bitmode write
    start_cycle(16'h1234, 1'b0);
    check("plain_bitmd", {31'd0, BITMDn}, 32'd1);
    check("plain_drba",  {17'd0, DRBA}, 32'h1234);
    end_cycle(8'h99);
    peek("plain_xy", 15'h7F88, 1'b0);

    // Reset mid bitmode cycle discards the pending step
    xinc_n = 1'b0; yinc_n = 1'b0;
    start_cycle(ADDR_BM, 1'b0);
    #2 reset_n = 1'b0;
    #3;
    check("mrst_drba",  {17'd0, DRBA}, 32'd0);
    check("mrst_bitmd", {31'd0, BITMDn}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    end_cycle(8'h00);
    xinc_n = 1'b1; yinc_n = 1'b1;
    peek("mrst_xy", 15'h0000, 1'b0);

    // Readback of Y
    cpu_write(ADDR_Y, 8'h5A);
    start_cycle(ADDR_Y, 1'b1);
`ifdef BITMAP_READBACK_EN
    check("rb_hit",  {31'd0, xy_rd_hit}, 32'd1);
    check("rb_data", {24'd0, xy_to_cpu}, 32'h5A);
`else
    check("rb_hit",  {31'd0, xy_rd_hit}, 32'd0);
    check("rb_data", {24'd0, xy_to_cpu}, 32'hFF);
`endif
    check("rb_drba", {17'd0, DRBA}, 32'h0001);
    end_cycle(8'h00);
    peek("rb_y", 15'h2D00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
